fetch_prefetch: RTL and testbench

//  Fetch stage with a parametrised prefetch queue and imem request handshake.

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/fetch_prefetch_if.sv | 32 +++
 rtl/fetch_prefetch_queue.sv | 54 +++++
 rtl/fetch_prefetch.sv | 91 +++++++++
 tb/tb_fetch_prefetch.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, PC source select, fetch queue entry.
// redirect_target() computes the fetch PC for a decode/execute redirect.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    Norm = 2'b00,
    Bran = 2'b01,
    PCJr = 2'b10,
    PCJ  = 2'b11
  } pcsrc_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fq_entry_t;

  function automatic word_t redirect_target(
    input pcsrc_t      src,
    input word_t       rpc,
    input logic [15:0] imm16,
    input word_t       jr,
    input logic [25:0] j26
  );
    word_t seq;
    seq = rpc + 32'd4;
    case (src)
      Bran:    redirect_target = seq + {{14{imm16[15]}}, imm16, 2'b00};
      PCJr:    redirect_target = jr;
      PCJ:     redirect_target = {rpc[31:28], j26, 2'b00};
      default: redirect_target = seq;
    endcase
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch bus bundle: imem request/response and fetch->decode handshake.
// master = fetch stage side, slave = memory/decode side.
interface fetch_prefetch_if;
  import cpu_types_pkg::*;

  logic  imem_ren;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_data;
  logic  fetch_valid;
  word_t fetch_instr;
  word_t fetch_pc;
  word_t fetch_npc;
  logic  fetch_ready;

  modport master (
    output imem_ren, imem_addr,
    input  imem_ready, imem_data,
    output fetch_valid, fetch_instr,
    output fetch_pc, fetch_npc,
    input  fetch_ready
  );

  modport slave (
    input  imem_ren, imem_addr,
    output imem_ready, imem_data,
    input  fetch_valid, fetch_instr,
    input  fetch_pc, fetch_npc,
    output fetch_ready
  );

endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_queue: circular FIFO with push, pop, flush; exposes count and head.
// Ports: CLK, nRST, i_push/i_data, i_pop, i_flush, o_count, o_head.
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  assign w_pop = i_pop && (r_cnt != '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: holds fetch PC, issues one imem request at a time,
// queues {instr, pc} for decode, and applies PCSrc redirects.
// Ports: CLK, nRST, halt, redirect bundle (pcsrc, redirect_pc,
// imm16, jr_target, jaddr26), bus (imem + fetch handshake).
module fetch_prefetch
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0,
  parameter int    QDEPTH  = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        redirect,
  input  pcsrc_t      pcsrc,
  input  word_t       redirect_pc,
  input  logic [15:0] imm16,
  input  word_t       jr_target,
  input  logic [25:0] jaddr26,
  fetch_prefetch_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  word_t         r_fpc;
  logic          r_pend;
  logic          r_squash;
  logic [CW-1:0] w_count;
  fq_entry_t     w_head;
  fq_entry_t     w_push_data;
  word_t         w_target;
  logic          w_ren;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  assign w_target = redirect_target(
    pcsrc, redirect_pc, imm16, jr_target, jaddr26);

  // A pending request stays raised until answered; memory cannot cancel.
  assign w_ren = nRST && (r_pend ||
    (!halt && !redirect && (w_count < QFULL)));

  // Responses only count while a request is actually raised.
  assign w_resp  = w_ren && bus.imem_ready;
  assign w_push  = w_resp && !r_squash && !redirect;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && bus.fetch_ready && !redirect;

  assign w_push_data.instr = bus.imem_data;
  assign w_push_data.pc    = r_fpc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fpc    <= PC_INIT;
      r_pend   <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      r_pend <= w_ren && !bus.imem_ready;
      if (redirect)    r_fpc <= w_target;
      else if (w_push) r_fpc <= r_fpc + 32'd4;
      // Late answer to a pre-redirect request must be dropped.
      if (w_resp)                  r_squash <= 1'b0;
      else if (redirect && r_pend) r_squash <= 1'b1;
    end
  end

  fetch_queue #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.imem_ren    = w_ren;
  assign bus.imem_addr   = r_fpc;
  assign bus.fetch_valid = w_valid;
  assign bus.fetch_instr = w_valid ? w_head.instr : '0;
  assign bus.fetch_pc    = w_valid ? w_head.pc : '0;
  assign bus.fetch_npc   = w_valid ? (w_head.pc + 32'd4) : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios then random traffic,
// checked against a queue-based reference model and a memory model.
module tb_fetch_prefetch;
  import cpu_types_pkg::*;

  localparam int QD = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  pcsrc_t      pcsrc = Norm;
  word_t       redirect_pc = '0;
  logic [15:0] imm16 = '0;
  word_t       jr_target = '0;
  logic [25:0] jaddr26 = '0;

  fetch_prefetch_if bus ();

  fetch_prefetch #(
    .PC_INIT (32'h0),
    .QDEPTH  (QD)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .halt        (halt),
    .redirect    (redirect),
    .pcsrc       (pcsrc),
    .redirect_pc (redirect_pc),
    .imm16       (imm16),
    .jr_target   (jr_target),
    .jaddr26     (jaddr26),
    .bus         (bus.master)
  );

  always #5 CLK = ~CLK;

  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  word_t mq[$];
  word_t m_fpc = '0;
  bit    m_busy = 0;
  int    m_wait = 0;
  word_t m_addr = '0;
  int    m_epoch = 0;
  int    epoch = 0;
  int    lat = 0;
  word_t popped[$];
  word_t pop_npc[$];
  word_t reqs[$];

  function automatic word_t mem_word(word_t a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic word_t ref_target(
    pcsrc_t s, word_t rpc, logic [15:0] imm,
    word_t jr, logic [25:0] j);
    int off;
    off = $signed(imm);
    off = off * 4;
    case (s)
      Norm:    return rpc + 32'd4;
      Bran:    return rpc + 32'd4 + word_t'(off);
      PCJr:    return jr;
      default: return (rpc & 32'hF000_0000) | (word_t'(j) << 2);
    endcase
  endfunction

  task automatic chk(string tag, word_t obs, word_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit    pend;
    bit    live;
    bit    pop;
    word_t tgt;
    word_t hpc;
    word_t hnpc;
    @(negedge CLK);
    #1;
    pend = m_busy;
    chk("ren", 32'(bus.imem_ren),
      32'(pend || (!halt && !redirect && mq.size() < QD)));
    if (bus.imem_ren && !m_busy) begin
      m_busy  = 1;
      m_addr  = bus.imem_addr;
      m_wait  = lat;
      m_epoch = epoch;
      chk("addr", bus.imem_addr, m_fpc);
      reqs.push_back(bus.imem_addr);
    end
    bus.imem_ready = 1'b0;
    bus.imem_data  = $urandom;
    if (m_busy) begin
      if (m_wait == 0) begin
        bus.imem_ready = 1'b1;
        bus.imem_data  = mem_word(m_addr);
      end else begin
        m_wait--;
      end
    end
    chk("valid", 32'(bus.fetch_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("pc", bus.fetch_pc, mq[0]);
      chk("instr", bus.fetch_instr, mem_word(mq[0]));
      chk("npc", bus.fetch_npc, mq[0] + 32'd4);
    end
    hpc  = bus.fetch_pc;
    hnpc = bus.fetch_npc;
    pop  = (mq.size() != 0) && bus.fetch_ready && !redirect;
    live = bus.imem_ready && !redirect && (m_epoch == epoch);
    tgt  = ref_target(pcsrc, redirect_pc, imm16,
      jr_target, jaddr26);
    @(posedge CLK);
    #1;
    if (bus.imem_ready) m_busy = 0;
    if (redirect) begin
      mq.delete();
      m_fpc = tgt;
      epoch++;
    end else begin
      if (pop) begin
        popped.push_back(hpc);
        pop_npc.push_back(hnpc);
        void'(mq.pop_front());
      end
      if (live) begin
        mq.push_back(m_addr);
        m_fpc = m_addr + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rst_ren", 32'(bus.imem_ren), 32'd0);
    chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_instr", bus.fetch_instr, 32'd0);
    chk("rst_pc", bus.fetch_pc, 32'd0);
    chk("rst_npc", bus.fetch_npc, 32'd0);
    m_busy = 0;
    mq.delete();
    m_fpc = 32'h0;
    epoch++;
    bus.imem_ready = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  function automatic word_t at(ref word_t q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic redir(pcsrc_t s, word_t rpc,
    logic [15:0] imm, word_t jr, logic [25:0] j);
    pcsrc = s;
    redirect_pc = rpc;
    imm16 = imm;
    jr_target = jr;
    jaddr26 = j;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    bus.imem_ready  = 1'b0;
    bus.imem_data   = '0;
    bus.fetch_ready = 1'b0;

    // 1: streaming with zero-latency memory
    do_reset();
    lat = 0;
    bus.fetch_ready = 1'b1;
    popped.delete();
    repeat (8) tick();
    chk("t1_pc0", at(popped, 0), 32'h0);
    chk("t1_pc1", at(popped, 1), 32'h4);
    chk("t1_pc2", at(popped, 2), 32'h8);
    chk("t1_pc3", at(popped, 3), 32'hC);

    // 2: queue fills then drains in order
    do_reset();
    bus.fetch_ready = 1'b0;
    reqs.delete();
    popped.delete();
    repeat (8) tick();
    chk("t2_reqs", 32'(reqs.size()), 32'd4);
    chk("t2_ren", 32'(bus.imem_ren), 32'd0);
    bus.fetch_ready = 1'b1;
    repeat (10) tick();
    chk("t2_pop0", at(popped, 0), 32'h0);
    chk("t2_pop3", at(popped, 3), 32'hC);
    chk("t2_pop4", at(popped, 4), 32'h10);
    chk("t2_req4", at(reqs, 4), 32'h10);

    // 3: branch back and PCJ
    bus.fetch_ready = 1'b0;
    repeat (3) tick();
    reqs.delete();
    redir(Bran, 32'h20, 16'hFFFE, '0, '0);
    chk("t3_flush", 32'(bus.fetch_valid), 32'd0);
    tick();
    chk("t3_bran", at(reqs, 0), 32'h1C);
    repeat (2) tick();
    reqs.delete();
    redir(PCJ, 32'h4000_0000, '0, '0, 26'd1);
    tick();
    chk("t3_pcj", at(reqs, 0), 32'h4000_0004);

    // 4: redirect during a pending fetch, then reset mid-fetch
    bus.fetch_ready = 1'b1;
    lat = 3;
    for (int k = 0; k < 20 && !(m_busy && m_wait > 0); k++)
      tick();
    chk("t4_pend", 32'(bus.imem_ren), 32'd1);
    reqs.delete();
    popped.delete();
    redir(PCJr, '0, '0, 32'h100, '0);
    repeat (15) tick();
    chk("t4_req", at(reqs, 0), 32'h100);
    chk("t4_pop", at(popped, 0), 32'h100);
    for (int k = 0; k < 20 && !(m_busy && m_wait > 0); k++)
      tick();
    do_reset();
    repeat (6) tick();

    // 5: PC wrap at the top of the address space
    lat = 0;
    popped.delete();
    pop_npc.delete();
    redir(PCJr, '0, '0, 32'hFFFF_FFFC, '0);
    repeat (6) tick();
    chk("t5_pc", at(popped, 0), 32'hFFFF_FFFC);
    chk("t5_npc", at(pop_npc, 0), 32'h0);
    chk("t5_next", at(popped, 1), 32'h0);

    // 6: halt mid-stream
    lat = 2;
    bus.fetch_ready = 1'b0;
    repeat (4) tick();
    halt = 1'b1;
    bus.fetch_ready = 1'b1;
    popped.delete();
    repeat (12) tick();
    chk("t6_ren", 32'(bus.imem_ren), 32'd0);
    chk("t6_drain", 32'(bus.fetch_valid), 32'd0);
    halt = 1'b0;
    reqs.delete();
    tick();
    chk("t6_resume", at(reqs, 0),
      popped.size() > 0 ? popped[popped.size()-1] + 32'd4
                        : 32'hDEAD_BEEF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(0, 3);
      bus.fetch_ready = ($urandom % 4) != 0;
      halt = ($urandom % 8) == 0;
      redirect = ($urandom % 12) == 0;
      pcsrc = pcsrc_t'($urandom_range(0, 3));
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      imm16 = 16'($urandom);
      jr_target = $urandom & 32'hFFFF_FFFC;
      jaddr26 = 26'($urandom);
      tick();
    end
    redirect = 1'b0;
    halt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
